// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and its line
// synchroniser (also used by the scan-code receiver).
//   ps2_tx_state_t : transmitter FSM states
//   ERR_*          : err_code values reported by ps2_host_tx
//   GLITCH_CYC     : cycles a new clock level must persist when the glitch
//                    filter (PS2_HOST_TX_GLITCH_FILTER_EN) is compiled in
//   odd_parity()   : PS/2 frame parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FAIL
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int GLITCH_CYC = 8;

    // Parity bit that makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS2_CLK / PS2_DAT pins into the system clock
// domain and flags falling edges of the PS/2 clock.
//
// Optional macro PS2_HOST_TX_GLITCH_FILTER_EN: when defined, the synchronised
// clock must hold a new level for GLITCH_CYC consecutive cycles before
// clk_level follows it; shorter pulses never reach the edge detector.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ps2_clk      raw PS2_CLK pin
//   ps2_dat      raw PS2_DAT pin
//   clk_level    synchronised (optionally filtered) PS/2 clock level
//   dat_level    synchronised PS/2 data level
//   clk_fall     one-cycle strobe: clk_level was 1 last cycle and is 0 now
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_level,
    output logic dat_level,
    output logic clk_fall
);

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;

    // Flops reset to 1 (idle bus level) so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign dat_level = dat_sync[1];

`ifdef PS2_HOST_TX_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(GLITCH_CYC);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(GLITCH_CYC - 1);

    logic             clk_filt;
    logic [CNT_W-1:0] run_cnt;

    // run_cnt counts consecutive cycles the synced level disagrees with the
    // filtered one; the filtered level flips on the GLITCH_CYC-th such cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            run_cnt  <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            run_cnt <= '0;
        end else if (run_cnt == RUN_LAST) begin
            clk_filt <= clk_sync[1];
            run_cnt  <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign clk_level = clk_filt;
`else
    assign clk_level = clk_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_level;
        end
    end

    assign clk_fall = clk_prev & ~clk_level;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte to a
// keyboard or mouse over the open-drain PS2_CLK / PS2_DAT pair. The chip top
// turns each *_oe into an open-drain driver (0 when oe=1, else 'z').
//
// Optional macro PS2_HOST_TX_GLITCH_FILTER_EN enables the PS2_CLK glitch
// filter inside ps2_line_sync.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   INHIBIT_US  clock-low inhibit time before a request, in us
//   TIMEOUT_MS  limit from request release to ACK completion, in ms
//
// Ports:
//   CLOCK_50, RESET_N   system clock, asynchronous active-low reset
//   tx_valid, tx_data   send request and command byte
//   tx_ready            idle; a request is accepted this cycle if tx_valid=1
//   busy                transfer in progress (receiver should ignore the bus)
//   done                one-cycle pulse: byte acknowledged and lines idle
//   err                 one-cycle pulse: transfer failed
//   err_code            01 no ACK, 10 timeout; held until the next accept
//   ps2_clk_i/ps2_dat_i raw bus pins
//   ps2_clk_oe/ps2_dat_oe  1 = pull the line low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15
)(
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int REQ_CYC = CLK_HZ / 1_000_000;
    localparam int TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int CNT_W   = $clog2(TO_CYC + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

    ps2_tx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       frame;
    logic             clk_level;
    logic             dat_level;
    logic             clk_fall;
    logic             in_xfer;

    ps2_line_sync u_sync (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .ps2_clk   (ps2_clk_i),
        .ps2_dat   (ps2_dat_i),
        .clk_level (clk_level),
        .dat_level (dat_level),
        .clk_fall  (clk_fall)
    );

    // States in which the device owns the clock and the timeout runs.
    assign in_xfer = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // cnt was cleared on SEND entry, so this fires exactly TO_CYC
            // cycles after the request was released.
            if (in_xfer && cnt == TO_LAST) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                err        <= 1'b1;
                err_code   <= ERR_TIMEOUT;
                state      <= ST_FAIL;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tx_valid) begin
                            // Shifted out LSB first: data, parity, stop(1).
                            frame      <= {1'b1, odd_parity(tx_data), tx_data};
                            err_code   <= ERR_NONE;
                            cnt        <= '0;
                            ps2_clk_oe <= 1'b1;
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= ST_INHIBIT;
                        end
                    end

                    ST_INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            cnt        <= '0;
                            ps2_dat_oe <= 1'b1;  // start bit
                            state      <= ST_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    ST_REQ: begin
                        if (cnt == REQ_LAST) begin
                            cnt        <= '0;
                            bit_idx    <= '0;
                            ps2_clk_oe <= 1'b0;  // hand the clock to the device
                            state      <= ST_SEND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    ST_SEND: begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            ps2_dat_oe <= ~frame[0];
                            frame      <= {1'b0, frame[9:1]};
                            if (bit_idx == 4'd9) begin
                                state <= ST_ACK;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end

                    ST_ACK: begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            if (!dat_level) begin
                                state <= ST_WAIT_IDLE;
                            end else begin
                                ps2_clk_oe <= 1'b0;
                                ps2_dat_oe <= 1'b0;
                                err        <= 1'b1;
                                err_code   <= ERR_NOACK;
                                state      <= ST_FAIL;
                            end
                        end
                    end

                    ST_WAIT_IDLE: begin
                        cnt <= cnt + 1'b1;
                        if (clk_level && dat_level) begin
                            done     <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end

                    ST_FAIL: begin
                        // err is high during this cycle; lines already released.
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end

                    default: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
